// File: rtl/sap_controller.sv
// SAP-1 style control sequencer: a one-hot T-state ring clocked on the falling edge with combinational strobe decode.
// Optional macro SAP_CTRL_JMP_EN adds the PCLoad output and decodes JMP (0011).
`timescale 1ns/1ps
module sap_controller #(
    parameter int TSTATES = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         Opcode,
    output logic [TSTATES-1:0] TState,
    output logic               PCInc,
    output logic               PCOut,
    output logic               MARIn,
    output logic               RAMOut,
    output logic               IRIn,
    output logic               IROut,
    output logic               AIn,
    output logic               AOut,
    output logic               BIn,
    output logic               ALUSub,
    output logic               ALUOut,
    output logic               OutIn,
`ifdef SAP_CTRL_JMP_EN
    output logic               PCLoad,
`endif
    output logic               Halt
);

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_JMP = 4'b0011;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [TSTATES-1:0] T1 = TSTATES'(1);
    localparam logic [TSTATES-1:0] T2 = TSTATES'(2);
    localparam logic [TSTATES-1:0] T3 = TSTATES'(4);
    localparam logic [TSTATES-1:0] T4 = TSTATES'(8);
    localparam logic [TSTATES-1:0] T5 = TSTATES'(16);
    localparam logic [TSTATES-1:0] T6 = TSTATES'(32);

    generate
        if (TSTATES < 6 || TSTATES > 8) begin : g_bad_tstates
            $error("sap_controller: TSTATES must be 6..8");
        end
    endgenerate

    logic [TSTATES-1:0] tstate_q, tstate_d;
    logic               halt_q, halt_d;
    logic               run;

    // HLT is caught on the T3->T4 edge so the ring parks on T4 and never wraps.
    always_comb begin
        tstate_d = tstate_q;
        halt_d   = halt_q;
        if (!halt_q) begin
            if (tstate_q == T3 && Opcode == OP_HLT) begin
                tstate_d = T4;
                halt_d   = 1'b1;
            end else if (!$onehot(tstate_q)) begin
                tstate_d = T1;
            end else begin
                tstate_d = {tstate_q[TSTATES-2:0], tstate_q[TSTATES-1]};
            end
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            tstate_q <= T1;
            halt_q   <= 1'b0;
        end else begin
            tstate_q <= tstate_d;
            halt_q   <= halt_d;
        end
    end

    assign TState = tstate_q;
    assign Halt   = halt_q;
    assign run    = rst && !halt_q;

    // Strobes are gated by rst directly so nothing leaks while reset is held.
    always_comb begin
        PCInc  = 1'b0;
        PCOut  = 1'b0;
        MARIn  = 1'b0;
        RAMOut = 1'b0;
        IRIn   = 1'b0;
        IROut  = 1'b0;
        AIn    = 1'b0;
        AOut   = 1'b0;
        BIn    = 1'b0;
        ALUSub = 1'b0;
        ALUOut = 1'b0;
        OutIn  = 1'b0;
`ifdef SAP_CTRL_JMP_EN
        PCLoad = 1'b0;
`endif
        if (run) begin
            case (tstate_q)
                T1: begin
                    PCOut = 1'b1;
                    MARIn = 1'b1;
                end
                T2: PCInc = 1'b1;
                T3: begin
                    RAMOut = 1'b1;
                    IRIn   = 1'b1;
                end
                T4: begin
                    case (Opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            IROut = 1'b1;
                            MARIn = 1'b1;
                        end
                        OP_OUT: begin
                            AOut  = 1'b1;
                            OutIn = 1'b1;
                        end
`ifdef SAP_CTRL_JMP_EN
                        OP_JMP: begin
                            IROut  = 1'b1;
                            PCLoad = 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
                T5: begin
                    case (Opcode)
                        OP_LDA: begin
                            RAMOut = 1'b1;
                            AIn    = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            RAMOut = 1'b1;
                            BIn    = 1'b1;
                            ALUSub = (Opcode == OP_SUB);
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    if (Opcode == OP_ADD || Opcode == OP_SUB) begin
                        ALUOut = 1'b1;
                        AIn    = 1'b1;
                        ALUSub = (Opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    // JMP is a plain NOP in the default build; the constant keeps it referenced.
    logic unused_jmp;
    assign unused_jmp = (OP_JMP == 4'b0011);

endmodule

// File: tb/tb_sap_controller.sv
// Randomised scoreboard bench for sap_controller: a microprogram-table model predicts each cycle's state and strobes.
`timescale 1ns/1ps
module tb_sap_controller;

    localparam int TS = 6;
`ifdef SAP_CTRL_JMP_EN
    localparam bit JMP_EN = 1'b1;
`else
    localparam bit JMP_EN = 1'b0;
`endif

    localparam logic [12:0] M_PCINC  = 13'h1000;
    localparam logic [12:0] M_PCOUT  = 13'h0800;
    localparam logic [12:0] M_MARIN  = 13'h0400;
    localparam logic [12:0] M_RAMOUT = 13'h0200;
    localparam logic [12:0] M_IRIN   = 13'h0100;
    localparam logic [12:0] M_IROUT  = 13'h0080;
    localparam logic [12:0] M_AIN    = 13'h0040;
    localparam logic [12:0] M_AOUT   = 13'h0020;
    localparam logic [12:0] M_BIN    = 13'h0010;
    localparam logic [12:0] M_ALUSUB = 13'h0008;
    localparam logic [12:0] M_ALUOUT = 13'h0004;
    localparam logic [12:0] M_OUTIN  = 13'h0002;
    localparam logic [12:0] M_PCLOAD = 13'h0001;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    Opcode;
    logic [TS-1:0] TState;
    logic PCInc, PCOut, MARIn, RAMOut, IRIn, IROut, AIn, AOut, BIn, ALUSub, ALUOut, OutIn, Halt;
    logic PCLoad_w;

    sap_controller #(.TSTATES(TS)) dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .TState(TState),
        .PCInc(PCInc), .PCOut(PCOut), .MARIn(MARIn), .RAMOut(RAMOut), .IRIn(IRIn),
        .IROut(IROut), .AIn(AIn), .AOut(AOut), .BIn(BIn), .ALUSub(ALUSub),
        .ALUOut(ALUOut), .OutIn(OutIn),
`ifdef SAP_CTRL_JMP_EN
        .PCLoad(PCLoad_w),
`endif
        .Halt(Halt)
    );
`ifndef SAP_CTRL_JMP_EN
    assign PCLoad_w = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [TS-1:0] ts;
        logic          halt;
        logic [12:0]   str;
        int            t;
        logic [3:0]    op;
    } exp_t;

    exp_t        exp_q[$];
    logic [12:0] prog [16][8];
    int          m_t;
    bit          m_h;
    bit          done = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    // Microprogram: row = opcode, column = T-state index (0 = T1).
    task automatic init_prog();
        for (int op = 0; op < 16; op++) begin
            for (int t = 0; t < 8; t++) prog[op][t] = '0;
            prog[op][0] = M_PCOUT | M_MARIN;
            prog[op][1] = M_PCINC;
            prog[op][2] = M_RAMOUT | M_IRIN;
        end
        prog[0][3] = M_IROUT | M_MARIN;
        prog[0][4] = M_RAMOUT | M_AIN;
        for (int op = 1; op <= 2; op++) begin
            prog[op][3] = M_IROUT | M_MARIN;
            prog[op][4] = M_RAMOUT | M_BIN | ((op == 2) ? M_ALUSUB : 13'h0);
            prog[op][5] = M_ALUOUT | M_AIN | ((op == 2) ? M_ALUSUB : 13'h0);
        end
        prog[14][3] = M_AOUT | M_OUTIN;
        if (JMP_EN) prog[3][3] = M_IROUT | M_PCLOAD;
    endtask

    task automatic push_exp(input bit in_rst);
        exp_t e;
        e.t    = in_rst ? 1 : m_t;
        e.op   = Opcode;
        e.ts   = TS'(1) << (e.t - 1);
        e.halt = in_rst ? 1'b0 : m_h;
        e.str  = (in_rst || m_h) ? 13'h0 : prog[Opcode][e.t - 1];
        exp_q.push_back(e);
    endtask

    // Called 2 ns after a rising edge; predicts the state entered at the next falling edge.
    task automatic step(input logic [3:0] instr);
        int nt;
        if (m_h) begin
            Opcode = 4'($urandom);
        end else begin
            nt = (m_t == TS) ? 1 : m_t + 1;
            Opcode = (nt >= 4) ? instr : 4'($urandom);
            if (m_t == 3 && instr == 4'b1111) begin
                m_t = 4;
                m_h = 1'b1;
            end else begin
                m_t = nt;
            end
        end
        push_exp(1'b0);
        @(posedge clk); #2;
    endtask

    // Reset held 12 ns, released between a falling and the next rising edge.
    task automatic reset_slot();
        Opcode = 4'($urandom);
        push_exp(1'b1);
        #4 rst = 1'b0;
        #12 rst = 1'b1;
        m_t = 1;
        m_h = 1'b0;
        push_exp(1'b0);
        @(posedge clk); #2;
    endtask

    function automatic logic [3:0] pick_instr(input int n);
        logic [3:0] dir [8] = '{4'h0, 4'h1, 4'h2, 4'he, 4'h5, 4'h3, 4'hf, 4'h0};
        logic [3:0] pool [7] = '{4'h0, 4'h1, 4'h2, 4'he, 4'hf, 4'h3, 4'h5};
        if (n < 7) return dir[n];
        if ($urandom_range(0, 3) == 0) return 4'($urandom);
        return pool[$urandom_range(0, 6)];
    endfunction

    initial begin
        logic [3:0] instr;
        init_prog();
        rst = 1'b1;
        Opcode = 4'h0;
        m_t = 1;
        m_h = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk); #2;
        reset_slot();
        for (int n = 0; n < 70; n++) begin
            instr = pick_instr(n);
            do step(instr); while (m_t != 1 && !m_h);
            if (m_h) begin
                repeat (12) step(instr);
                reset_slot();
            end else if ($urandom_range(0, 7) == 0) begin
                instr = pick_instr(99);
                repeat ($urandom_range(1, 5)) step(instr);
                reset_slot();
            end
        end
        done = 1'b1;
    end

    initial begin
        exp_t e;
        logic [12:0] act;
        int drivers;
        while (!done) begin
            @(posedge clk); #1;
            act = {PCInc, PCOut, MARIn, RAMOut, IRIn, IROut, AIn, AOut, BIn, ALUSub, ALUOut, OutIn, PCLoad_w};
            drivers = int'(PCOut) + int'(RAMOut) + int'(IROut) + int'(AOut) + int'(ALUOut);
            n_checks++;
            if (drivers > 1) begin
                n_fail++;
                $display("FAIL bus_onehot t=%0t drivers=%0d required<=1", $time, drivers);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (TState !== e.ts || Halt !== e.halt) begin
                    n_fail++;
                    $display("FAIL state t=%0t TState=%b Halt=%b required TState=%b Halt=%b (rst=%b op=%h)",
                             $time, TState, Halt, e.ts, e.halt, rst, e.op);
                end
                n_checks++;
                if (act !== e.str) begin
                    n_fail++;
                    $display("FAIL strobes t=%0t T%0d op=%h rst=%b got=%b required=%b",
                             $time, e.t, e.op, rst, act, e.str);
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain leftover=%0d required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog time=%0t limit reached", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sap_controller.md
SAP_CONTROLLER -- requirements
Module: sap_controller

Interface
REQ-001 SHALL have parameter TSTATES, default 6, giving the ring-counter length (legal 6..8); states T7..T8, when present, are no-op states.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low (0 = reset).
REQ-004 SHALL have port Opcode, input, 4 bits: the instruction register upper nibble.
REQ-005 SHALL have port TState, output, TSTATES bits: the one-hot timing state, with bit0 = T1.
REQ-006 SHALL have 1-bit output ports PCInc, PCOut, MARIn, RAMOut, IRIn, IROut, AIn, AOut, BIn, ALUSub, ALUOut and OutIn, each being the active-high load/enable strobe of the matching datapath block.
REQ-007 SHALL have port Halt, output, 1 bit: processor stopped.

Function
REQ-008 SHALL advance TState one position on each falling clk edge (T1->T2->...->T<TSTATES>->T1), so that strobes are stable before the rising edge on which datapath registers load.
REQ-009 SHALL decode the strobes combinationally from TState and Opcode; any strobe not listed for a state SHALL be 0.
REQ-010 SHALL assert in the fetch states, for every opcode: T1 PCOut+MARIn; T2 PCInc; T3 RAMOut+IRIn.
REQ-011 SHALL decode LDA (0000) as: T4 IROut+MARIn; T5 RAMOut+AIn; T6 none.
REQ-012 SHALL decode ADD (0001) as: T4 IROut+MARIn; T5 RAMOut+BIn; T6 ALUOut+AIn.
REQ-013 SHALL decode SUB (0010) exactly as ADD, with ALUSub additionally asserted in T5 and T6.
REQ-014 SHALL decode OUT (1110) as: T4 AOut+OutIn; T5..T<TSTATES> none.
REQ-015 SHALL, for HLT (1111), on the falling edge that enters T4, set Halt=1 and freeze TState at T4, with all strobes 0 thereafter until reset.
REQ-016 SHALL treat any other opcode (not enabled by REQ-022) as a NOP: no strobes in T4..T<TSTATES>, and the ring continues.
REQ-017 SHALL guarantee that at most one bus driver (PCOut, RAMOut, IROut, AOut, ALUOut) is asserted in any state.
REQ-018 SHALL hold Opcode-dependent strobes to the Opcode value present during that state; an Opcode change during T1..T3 SHALL NOT affect those fetch states.

Reset
REQ-019 SHALL, while rst=0 (asynchronously), force TState to T1 (one-hot 0...01), Halt to 0, and every strobe to 0, regardless of state or Halt.
REQ-020 SHALL, after rst rises, drive the T1 strobes (PCOut+MARIn) immediately and take the first ring advance on the next falling clk edge.
REQ-021 SHALL make reset mid-instruction or while halted abort the instruction and restart at T1, with no partial strobes.

Configuration
REQ-022 SHALL, with macro SAP_CTRL_JMP_EN defined, add output PCLoad (1 bit) and decode JMP (0011) as: T4 IROut+PCLoad; T5..T<TSTATES> none; PCLoad SHALL reset to 0.
REQ-023 SHALL, without SAP_CTRL_JMP_EN, have no PCLoad port and treat 0011 as a NOP.

Verification
REQ-024 SHALL cover reset: rst=0 for 12 ns in any state -> TState=000001, Halt=0, all strobes 0; after release, PCOut=MARIn=1.
REQ-025 SHALL cover LDA: Opcode=0000, six falling edges -> strobes per state T1..T6 = {PCOut,MARIn},{PCInc},{RAMOut,IRIn},{IROut,MARIn},{RAMOut,AIn},{} and TState returns to 000001.
REQ-026 SHALL cover SUB: Opcode=0010 -> T5 = {RAMOut,BIn,ALUSub} and T6 = {ALUOut,AIn,ALUSub}; ADD (0001) gives the same with ALUSub=0.
REQ-027 SHALL cover HLT: Opcode=1111 -> Halt=1 at T4, TState stays 001000 for 10+ clocks with all strobes 0; rst=0 then releases to T1 with Halt=0.
REQ-028 SHALL cover OUT and illegal opcodes: OUT (1110) -> T4 = {AOut,OutIn}; 0101 -> T4..T6 empty and the ring wraps; a bus-driver one-hot check on every cycle.
REQ-029 SHALL cover JMP: with SAP_CTRL_JMP_EN, Opcode=0011 -> T4 = {IROut,PCLoad}; without it, 0011 -> empty T4..T6.
